// File: rtl/latch_bank_write_arbiter.sv
// Round-robin write arbiter driving a shared bank of level-sensitive D latches.
// Optional read-back verification of each write is enabled with the READBACK_CHECK_EN macro.
module latch_bank_write_arbiter #(
    parameter int N         = 4,
    parameter int W         = 8,
    parameter int DEPTH     = 4,
    parameter int SETUP_CYC = 1,
    parameter int EN_CYC    = 2,
    parameter int HOLD_CYC  = 1,
    localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic [N*AW-1:0]      req_addr,
    input  logic [N*W-1:0]       req_data,
    output logic [N-1:0]         ack,
    output logic                 busy,
    output logic                 addr_err,
    output logic [W-1:0]         latch_d,
    output logic [DEPTH-1:0]     latch_en,
`ifdef READBACK_CHECK_EN
    output logic                 wr_err,
`endif
    input  logic [DEPTH*W-1:0]   latch_q
);

    localparam int PW   = (N > 1) ? $clog2(N) : 1;
    localparam int MAXC = (SETUP_CYC > EN_CYC) ?
                          ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC) :
                          ((EN_CYC > HOLD_CYC) ? EN_CYC : HOLD_CYC);
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ENABLE,
        HOLD,
        DONE
    } state_t;

    state_t            state_q;
    logic [PW-1:0]     ptr_q;
    logic [PW-1:0]     grant_q;
    logic [AW-1:0]     addr_q;
    logic [CW-1:0]     cnt_q;
    logic [N-1:0]      ack_q;
    logic              busy_q;
    logic              addr_err_q;
    logic [W-1:0]      latch_d_q;
    logic [DEPTH-1:0]  latch_en_q;
    logic              wr_err_q;

    logic [PW-1:0]     winner_d;
    logic [PW-1:0]     ptr_d;
    logic [AW-1:0]     win_addr_d;
    logic [W-1:0]      win_data_d;
    logic [DEPTH-1:0]  en_vec_d;
    logic [W-1:0]      rd_word_d;
    logic              addr_oor_d;

    // First requester at or above the pointer, wrapping around
    always_comb begin
        logic found;
        int   idx;
        found      = 1'b0;
        idx        = 0;
        winner_d   = ptr_q;
        win_addr_d = '0;
        win_data_d = '0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_q) + k) % N;
            if (!found && req[idx]) begin
                found      = 1'b1;
                winner_d   = PW'(idx);
                win_addr_d = req_addr[idx*AW +: AW];
                win_data_d = req_data[idx*W +: W];
            end
        end
        ptr_d = (winner_d == PW'(N - 1)) ? '0 : winner_d + PW'(1);
    end

    // Out-of-range addresses match no word, so their enable vector stays all zero
    always_comb begin
        en_vec_d  = '0;
        rd_word_d = '0;
        for (int j = 0; j < DEPTH; j++) begin
            if (addr_q == AW'(j)) begin
                en_vec_d[j] = 1'b1;
                rd_word_d   = latch_q[j*W +: W];
            end
        end
        addr_oor_d = ({1'b0, addr_q} >= (AW+1)'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            grant_q    <= '0;
            addr_q     <= '0;
            cnt_q      <= '0;
            ack_q      <= '0;
            busy_q     <= 1'b0;
            addr_err_q <= 1'b0;
            latch_d_q  <= '0;
            latch_en_q <= '0;
            wr_err_q   <= 1'b0;
        end else begin
            ack_q      <= '0;
            addr_err_q <= 1'b0;
            wr_err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        state_q   <= SETUP;
                        busy_q    <= 1'b1;
                        grant_q   <= winner_d;
                        addr_q    <= win_addr_d;
                        latch_d_q <= win_data_d;
                        ptr_q     <= ptr_d;
                        cnt_q     <= CW'(SETUP_CYC - 1);
                    end
                end
                SETUP: begin
                    if (cnt_q == '0) begin
                        state_q    <= ENABLE;
                        latch_en_q <= en_vec_d;
                        cnt_q      <= CW'(EN_CYC - 1);
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                ENABLE: begin
                    if (cnt_q == '0) begin
                        state_q    <= HOLD;
                        latch_en_q <= '0;
                        cnt_q      <= CW'(HOLD_CYC - 1);
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                HOLD: begin
                    // latch_d_q still carries the written data here, so it doubles as the reference
                    if (cnt_q == '0) begin
                        state_q    <= DONE;
                        latch_d_q  <= '0;
                        ack_q      <= N'(1) << grant_q;
                        addr_err_q <= addr_oor_d;
                        wr_err_q   <= !addr_oor_d && (rd_word_d != latch_d_q);
                        cnt_q      <= '0;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q    <= IDLE;
                    busy_q     <= 1'b0;
                    latch_en_q <= '0;
                    latch_d_q  <= '0;
                end
            endcase
        end
    end

    assign ack      = ack_q;
    assign busy     = busy_q;
    assign addr_err = addr_err_q;
    assign latch_d  = latch_d_q;
    assign latch_en = latch_en_q;

`ifdef READBACK_CHECK_EN
    assign wr_err = wr_err_q;
`else
    logic unused_readback;
    assign unused_readback = wr_err_q ^ (^rd_word_d);
`endif

endmodule

// File: tb/tb_latch_bank_write_arbiter.sv
// Directed, table-driven bench for latch_bank_write_arbiter (default and DEPTH=3 instances).
// Read-back checks are compiled in when READBACK_CHECK_EN is defined.
module tb_latch_bank_write_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;

    logic [3:0]   req;
    logic [7:0]   reqAddr;
    logic [31:0]  reqData;
    logic [3:0]   ack;
    logic         busy;
    logic         addrErr;
    logic [7:0]   latchD;
    logic [3:0]   latchEn;
    logic [31:0]  latchQ;
    logic         wrErr;

    logic [3:0]   req3;
    logic [7:0]   reqAddr3;
    logic [31:0]  reqData3;
    logic [3:0]   ack3;
    logic         busy3;
    logic         addrErr3;
    logic [7:0]   latchD3;
    logic [2:0]   latchEn3;
    logic [23:0]  latchQ3;
    logic         wrErr3;

    logic [7:0]   latchMem [4];
    logic         forceZero;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    latch_bank_write_arbiter #(.N(4), .W(8), .DEPTH(4), .SETUP_CYC(1), .EN_CYC(2), .HOLD_CYC(1)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_addr(reqAddr), .req_data(reqData),
        .ack(ack), .busy(busy), .addr_err(addrErr), .latch_d(latchD), .latch_en(latchEn),
`ifdef READBACK_CHECK_EN
        .wr_err(wrErr),
`endif
        .latch_q(latchQ)
    );

    latch_bank_write_arbiter #(.N(4), .W(8), .DEPTH(3), .SETUP_CYC(1), .EN_CYC(2), .HOLD_CYC(1)) dut3 (
        .clk(clk), .rst_n(rst_n), .req(req3), .req_addr(reqAddr3), .req_data(reqData3),
        .ack(ack3), .busy(busy3), .addr_err(addrErr3), .latch_d(latchD3), .latch_en(latchEn3),
`ifdef READBACK_CHECK_EN
        .wr_err(wrErr3),
`endif
        .latch_q(latchQ3)
    );

`ifndef READBACK_CHECK_EN
    assign wrErr  = 1'b0;
    assign wrErr3 = 1'b0;
`endif
    assign latchQ3 = '0;

    // Behavioural latch bank: transparent while its enable is high
    always @(latchEn or latchD) begin
        for (int j = 0; j < 4; j++)
            if (latchEn[j]) latchMem[j] = latchD;
    end

    always_comb begin
        for (int j = 0; j < 4; j++)
            latchQ[j*8 +: 8] = forceZero ? 8'h00 : latchMem[j];
    end

    typedef struct {
        logic [3:0]  reqV;
        logic [7:0]  addrV;
        logic [31:0] dataV;
        int          expWinner;
        int          expAddr;
        logic [7:0]  expData;
        int          dropAt;
    } vecT;

    vecT vecs[8];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] reqV, input logic [7:0] addrV, input logic [31:0] dataV);
        req     = reqV;
        reqAddr = addrV;
        reqData = dataV;
    endtask

    // Grant edge, then SETUP, ENABLE x2, HOLD, DONE, IDLE sampled on the falling edges
    task automatic checkSequence(input int w, input int a, input logic [7:0] d, input int dropAt, input logic expWr);
        @(posedge clk);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checkOutput($sformatf("latch_d c%0d", c), 32'(latchD), (c <= 3) ? 32'(d) : 32'd0);
            checkOutput($sformatf("latch_en c%0d", c), 32'(latchEn), (c == 1 || c == 2) ? (32'd1 << a) : 32'd0);
            checkOutput($sformatf("ack c%0d", c), 32'(ack), (c == 4) ? (32'd1 << w) : 32'd0);
            checkOutput($sformatf("busy c%0d", c), 32'(busy), (c <= 4) ? 32'd1 : 32'd0);
            if (c == 4) begin
                checkOutput("addr_err done", 32'(addrErr), 32'd0);
`ifdef READBACK_CHECK_EN
                checkOutput("wr_err done", 32'(wrErr), 32'(expWr));
`endif
            end
            if (c == dropAt) begin
                req     = 4'b0000;
                reqData = 32'h0;
            end
        end
    endtask

    initial begin
        vecs[0] = '{4'b1111, 8'he4, 32'h13121110, 0, 0, 8'h10, -1};
        vecs[1] = '{4'b1111, 8'he4, 32'h13121110, 1, 1, 8'h11, -1};
        vecs[2] = '{4'b1111, 8'he4, 32'h13121110, 2, 2, 8'h12, -1};
        vecs[3] = '{4'b1111, 8'he4, 32'h13121110, 3, 3, 8'h13, -1};
        vecs[4] = '{4'b1111, 8'he4, 32'h13121110, 0, 0, 8'h10, -1};
        vecs[5] = '{4'b1001, 8'he4, 32'h13121110, 3, 3, 8'h13, -1};
        vecs[6] = '{4'b0100, 8'h10, 32'h00A50000, 2, 1, 8'hA5, -1};
        vecs[7] = '{4'b0010, 8'h08, 32'h00003C00, 1, 2, 8'h3C,  1};

        rst_n     = 1'b0;
        forceZero = 1'b0;
        applyStimulus(4'b0000, 8'h00, 32'h0);
        req3 = 4'b0000; reqAddr3 = 8'h00; reqData3 = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset ack", 32'(ack), 32'd0);
        checkOutput("reset latch_d", 32'(latchD), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput($sformatf("idle busy %0d", i), 32'(busy), 32'd0);
            checkOutput($sformatf("idle ack %0d", i), 32'(ack), 32'd0);
            checkOutput($sformatf("idle latch_en %0d", i), 32'(latchEn), 32'd0);
            checkOutput($sformatf("idle latch_d %0d", i), 32'(latchD), 32'd0);
        end

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].reqV, vecs[i].addrV, vecs[i].dataV);
            checkSequence(vecs[i].expWinner, vecs[i].expAddr, vecs[i].expData, vecs[i].dropAt, 1'b0);
        end
        checkOutput("latch word1", 32'(latchMem[1]), 32'h000000A5);

        // Reset during ENABLE: ptr is 2, so requester 2 wins first, then 1 after reset
        applyStimulus(4'b0110, 8'h30, 32'h00C35A00);
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst-mid setup latch_d", 32'(latchD), 32'h000000C3);
        @(negedge clk);
        checkOutput("rst-mid enable latch_en", 32'(latchEn), 32'h00000008);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("rst-mid latch_en", 32'(latchEn), 32'd0);
        checkOutput("rst-mid busy", 32'(busy), 32'd0);
        checkOutput("rst-mid ack", 32'(ack), 32'd0);
        checkOutput("rst-mid latch_d", 32'(latchD), 32'd0);
        rst_n = 1'b1;
        checkSequence(1, 0, 8'h5A, -1, 1'b0);
        applyStimulus(4'b0000, 8'h00, 32'h0);

        // DEPTH=3 instance, address 3 is out of range
        req3 = 4'b0001; reqAddr3 = 8'h03; reqData3 = 32'h00000077;
        @(posedge clk);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checkOutput($sformatf("d3 latch_en c%0d", c), 32'(latchEn3), 32'd0);
            checkOutput($sformatf("d3 latch_d c%0d", c), 32'(latchD3), (c <= 3) ? 32'h77 : 32'd0);
            checkOutput($sformatf("d3 ack c%0d", c), 32'(ack3), (c == 4) ? 32'd1 : 32'd0);
            checkOutput($sformatf("d3 addr_err c%0d", c), 32'(addrErr3), (c == 4) ? 32'd1 : 32'd0);
`ifdef READBACK_CHECK_EN
            checkOutput($sformatf("d3 wr_err c%0d", c), 32'(wrErr3), 32'd0);
`endif
            if (c == 0) req3 = 4'b0000;
        end

`ifdef READBACK_CHECK_EN
        // Latch outputs stuck at zero while 0xFF is written: ptr is 2, only requester 0 asks
        forceZero = 1'b1;
        applyStimulus(4'b0001, 8'h01, 32'h000000FF);
        checkSequence(0, 1, 8'hFF, 0, 1'b1);
        forceZero = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
